// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module  : muldiv_pkg
// Brief   : Shared types, M-extension encodings and decode helpers for the
//           iterative multiply/divide sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] funct3);
        return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
               (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] funct3);
        return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
               (funct3 == FUNCT3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_abs_neg.sv
//------------------------------------------------------------------------------
// Module  : muldiv_abs_neg
// Brief   : Combinational conditional two's-complement negate; used both for
//           operand absolute value and for final sign correction.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? (~in_val + WIDTH'(1)) : in_val;

endmodule

`default_nettype wire

// File: rtl/muldiv_seq_unit.sv
//------------------------------------------------------------------------------
// Module  : muldiv_seq_unit
// Brief   : Iterative RV32M multiply/divide sequencer: 32-step shift-add
//           multiply or restoring divide, sign fix, registered result.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_seq_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    import muldiv_pkg::*;

    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(XLEN-1);

    state_t           r_state;
    logic [2:0]       r_funct3;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [XLEN-1:0]  r_result;

    logic             w_neg_a;
    logic             w_neg_b;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [XLEN:0]    w_mul_sum;
    logic [XLEN:0]    w_div_shift;
    logic [XLEN+1:0]  w_div_diff;
    logic [XLEN-1:0]  w_hi_next;
    logic [XLEN-1:0]  w_lo_next;
    logic [2*XLEN-1:0] w_fix_wide;
    logic [XLEN-1:0]  w_fix_rem;
    logic [XLEN-1:0]  w_fix_result;

    assign w_neg_a    = is_signed_a(funct3_i) & op_a_i[XLEN-1];
    assign w_neg_b    = is_signed_b(funct3_i) & op_b_i[XLEN-1];
    assign w_div_zero = is_div(funct3_i) && (op_b_i == '0);
    assign w_div_ovf  = ((funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_REM)) &&
                        (op_a_i == c_int_min) && (op_b_i == '1);

    muldiv_abs_neg #(.WIDTH(XLEN)) u_abs_a (
        .in_val (op_a_i),
        .neg    (w_neg_a),
        .out_val(w_abs_a)
    );

    muldiv_abs_neg #(.WIDTH(XLEN)) u_abs_b (
        .in_val (op_b_i),
        .neg    (w_neg_b),
        .out_val(w_abs_b)
    );

    // {r_hi, r_lo} is the 64-bit product for multiply and {rem, quo} for divide
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};

    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (is_div(r_funct3)) begin
            if (!w_div_diff[XLEN+1]) begin
                w_hi_next = w_div_diff[XLEN-1:0];
                w_lo_next = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_next = w_div_shift[XLEN-1:0];
                w_lo_next = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {w_hi_next, w_lo_next} = {w_mul_sum, r_lo[XLEN-1:1]};
        end
    end

    // Low half of the wide negate is also the negated quotient
    muldiv_abs_neg #(.WIDTH(2*XLEN)) u_fix_wide (
        .in_val ({r_hi, r_lo}),
        .neg    (r_sign_a ^ r_sign_b),
        .out_val(w_fix_wide)
    );

    muldiv_abs_neg #(.WIDTH(XLEN)) u_fix_rem (
        .in_val (r_hi),
        .neg    (r_sign_a),
        .out_val(w_fix_rem)
    );

    always_comb begin
        w_fix_result = w_fix_wide[XLEN-1:0];
        case (r_funct3)
            FUNCT3_MUL:                            w_fix_result = w_fix_wide[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: w_fix_result = w_fix_wide[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:               w_fix_result = w_fix_wide[XLEN-1:0];
            default:                               w_fix_result = w_fix_rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_funct3 <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (kill_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_funct3 <= funct3_i;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        if (is_div(funct3_i)) begin
                            r_lo   <= w_abs_a;
                            r_opnd <= w_abs_b;
                        end else begin
                            r_lo   <= w_abs_b;
                            r_opnd <= w_abs_a;
                        end
                        if (w_div_zero) begin
                            r_result <= funct3_i[1] ? op_a_i : '1;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if (w_div_ovf) begin
                            r_result <= funct3_i[1] ? '0 : c_int_min;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi <= w_hi_next;
                    r_lo <= w_lo_next;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (r_state == ST_CALC) || (r_state == ST_FIX) ||
                      ((r_state == ST_IDLE) && start_i && !kill_i);
    assign done_o   = r_done & ~kill_i;
    assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_muldiv_seq_unit
// Brief   : Self-checking bench for muldiv_seq_unit: cycle-level timeline model
//           plus directed vectors with hand-computed results.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    muldiv_seq_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .funct3_i(funct3_i),
        .op_a_i  (op_a_i),
        .op_b_i  (op_b_i),
        .kill_i  (kill_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one M-op from plain arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin
                ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b};
                p = $signed(ea) * $signed(eb); return p[63:32];
            end
            3'd2: begin
                ea = {{32{a[31]}}, a}; eb = {32'b0, b};
                p = $signed(ea) * $signed(eb); return p[63:32];
            end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Timeline model: m_t = cycles since the accepting edge, -1 when idle
    int          m_t   = -1;
    int          m_lat = 34;
    logic [31:0] m_exp  = '0;
    logic [31:0] m_last = '0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_t    = -1;
            m_last = '0;
        end else if (kill_i) begin
            m_t = -1;
        end else if (m_t < 0) begin
            if (start_i) begin
                m_exp = model_res(funct3_i, op_a_i, op_b_i);
                m_lat = is_special(funct3_i, op_a_i, op_b_i) ? 1 : 34;
                m_t   = 1;
            end
        end else if (m_t == m_lat) begin
            m_last = m_exp;
            m_t    = -1;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk_i) begin
        logic busy_e, done_e;
        logic [31:0] res_e;
        if (!rst_ni) begin
            busy_e = 1'b0; done_e = 1'b0; res_e = '0;
        end else if (m_t < 0) begin
            busy_e = start_i && !kill_i; done_e = 1'b0; res_e = m_last;
        end else begin
            busy_e = (m_lat == 34) && (m_t <= 33);
            done_e = (m_t == m_lat) && !kill_i;
            res_e  = (m_t == m_lat) ? m_exp : m_last;
        end
        chk("cyc_busy", {31'b0, busy_o}, {31'b0, busy_e});
        chk("cyc_done", {31'b0, done_o}, {31'b0, done_e});
        chk("cyc_result", result_o, res_e);
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string nm);
        int n;
        n = 0;
        chk({nm, "_model"}, model_res(f3, a, b), exp_res);
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b;
        @(negedge clk_i);
        chk({nm, "_busy_T"}, {31'b0, busy_o}, 32'd1);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 1; i <= 100 && n == 0; i++) begin
            @(negedge clk_i);
            if (done_o) n = i;
        end
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_result"}, result_o, exp_res);
    endtask

    initial begin
        int pulses;
        int n;
        rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        funct3_i = '0; op_a_i = '0; op_b_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_result", result_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Multiply
        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7xm3");
        run_op(3'd1, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 34, "mulh_min_x2");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu_m1x2");
        run_op(3'd3, 32'h8000_0000, 32'd2,         32'h0000_0001, 34, "mulhu_x2");

        // Reset in the middle of CALC
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_busy", {31'b0, busy_o}, 32'd0);
        chk("midrst_done", {31'b0, done_o}, 32'd0);
        chk("midrst_result", result_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Divide
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        34, "divu_100_7");
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         34, "remu_100_7");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
        run_op(3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34, "rem_7_m2");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         34, "divu_min_max");
        run_op(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu_min_max");

        // Special divide cases
        run_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_5_0");
        run_op(3'd6, 32'd5,         32'd0,         32'd5,         1, "rem_5_0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem_ovf");

        // Kill at T+10 of a DIVU; previous result (0) must survive
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1 kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        @(negedge clk_i);
        chk("kill_busy", {31'b0, busy_o}, 32'd0);
        chk("kill_result", result_o, 32'h0);
        run_op(3'd5, 32'd1000, 32'd3, 32'd333, 34, "divu_after_kill");

        // start held high across a MULHU
        pulses = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = 3'd3; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF;
        for (int i = 0; i <= 34; i++) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        chk("held_pulses", pulses, 32'd1);
        chk("held_result", result_o, 32'hFFFF_FFFE);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("held_second_accept", {31'b0, busy_o}, 32'd1);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n = 0;
        for (int i = 1; i <= 60 && n == 0; i++) begin
            @(negedge clk_i);
            if (done_o) n = i;
        end
        chk("held_second_latency", n, 32'd34);

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Iterative RV32M multiply/divide sequencer in the EX stage, alongside the single-cycle ALU.
- Accepts one M-extension op (funct7 = 7'h01, OPCODE_R) per start pulse.
- Runs a 32-step shift-add multiply or restoring divide, applies sign correction, then returns a 32-bit result.
- Holds the pipeline via busy_o while it works.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  launch request; sampled only in IDLE
- funct3_i  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a_i  input  32  rs1 value
- op_b_i  input  32  rs2 value
- kill_i  input  1  pipeline flush; aborts the operation
- busy_o  output  1  high while the op is in flight; the hazard unit stalls IF/ID/EX on it
- done_o  output  1  one-cycle pulse when result_o is valid
- result_o  output  32  result; held stable until the next accepted start

Behaviour:
- Reset (async, rst_ni low):
  - state = IDLE; counter = 0.
  - busy_o = 0, done_o = 0, result_o = 32'h0.
  - All internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - When start_i = 1, latch funct3, operands and sign flags.
  - Signed ops (MULH, MULHSU a-side, DIV, REM) convert operands to absolute values.
  - Clear the accumulator, then:
    - divisor == 0 on DIV/DIVU/REM/REMU: go to DONE. Quotient = 32'hFFFF_FFFF; remainder = op_a_i.
    - DIV/REM with op_a_i = 32'h8000_0000 and op_b_i = 32'hFFFF_FFFF: go to DONE. Quotient = 32'h8000_0000; remainder = 0.
    - Otherwise: go to CALC with counter = 0.
- CALC (one iteration per cycle, exactly 32 cycles):
  - Multiply: if multiplier LSB = 1, add multiplicand into the upper half of the 64-bit product; shift the product right 1.
  - Divide: shift {rem, quo} left 1; trial-subtract the divisor from rem. If no borrow, keep the difference and set the quotient LSB.
  - When counter = 31, go to FIX; otherwise counter increments.
- FIX (1 cycle):
  - Multiply: negate the 64-bit product if sign_a XOR sign_b (MULHU: never; MULHSU: sign_a only).
  - Divide: negate the quotient if sign_a XOR sign_b; negate the remainder if sign_a.
  - Select the result: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quo; REM/REMU = rem.
  - Register the result into result_o; go to DONE.
- DONE (1 cycle): done_o = 1; go to IDLE.
- busy_o = 1 in CALC and FIX, plus the IDLE cycle in which start_i is accepted (combinational from start_i in IDLE).
- Latency, start accepted at cycle T:
  - Normal op: done_o at T+34.
  - Special divide cases: done_o at T+1.
- start_i while not in IDLE: ignored (no queueing).
- kill_i = 1 in any state:
  - Next state = IDLE; done_o is suppressed that cycle and never pulses for the killed op.
  - result_o keeps its previous value.
  - kill_i has priority over start_i in the same cycle.
- Reset mid-operation: immediate return to reset values; no done_o.
- Arithmetic is modulo 2^32 (2^64 for the product). No exceptions or flags are produced.

Decomposition:
- Add to opcode.svh, next to the existing FUNCT3_* definitions:
  - FUNCT7_MULDIV = 7'h01
  - FUNCT3_MUL … FUNCT3_REMU
- A new package muldiv_pkg holds:
  - the state enum
  - the is_signed_a / is_signed_b / is_div decode helper functions
- One sub-module: muldiv_abs_neg, a combinational two's-complement absolute/negate unit. It is instantiated for the operand abs step in IDLE and for the sign fix in FIX.
- The FSM and iteration datapath stay in the top module.

Test Plan:
1. Reset low mid-CALC, then release → busy_o = 0, done_o = 0, result_o = 0; the next start runs to completion normally.
2. MUL with a = 7, b = -3 (32'hFFFF_FFFD); then MULH with a = 32'h8000_0000, b = 2:
   - MUL: done_o at T+34, result_o = 32'hFFFF_FFEB.
   - MULH: result_o = 32'hFFFF_FFFF.
   - busy_o high T..T+33.
3. DIV -7/2 → 32'hFFFF_FFFD; REM -7/2 → 32'hFFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIV 5/0 → 32'hFFFF_FFFF; REM 5/0 → 5; DIV 32'h8000_0000 / -1 → 32'h8000_0000; REM of the same → 0. All four: done_o at T+1.
5. kill_i asserted at T+10 of a DIVU → IDLE at T+11, no done_o pulse, result_o unchanged; a start at T+12 is accepted.
6. start_i held high across a MULHU 32'hFFFF_FFFF × 32'hFFFF_FFFF → exactly one done_o pulse with result_o = 32'hFFFF_FFFE; the second op starts only from IDLE after DONE.
